// File: rtl/rv32_mmio_uart_tx_pkg.sv
// Shared types for the MMIO UART transmitter: bus request format, TX FSM
// states, register offsets and the divisor clamp helper.
package rv32_mmio_uart_tx_pkg;

  typedef enum logic [1:0] {
    MEM_NOP   = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } mem_op_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    mem_op_t     op;
  } memory_request_t;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_tx_state_t;

  localparam logic [1:0] UART_REG_TXDATA  = 2'd0;
  localparam logic [1:0] UART_REG_STATUS  = 2'd1;
  localparam logic [1:0] UART_REG_DIVISOR = 2'd2;

  // A divisor below 2 would leave no room for the bit counter to reload.
  function automatic logic [15:0] clamp_divisor(input logic [15:0] d);
    return (d < 16'd2) ? 16'd2 : d;
  endfunction

endpackage

// File: rtl/rv32_sync_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module rv32_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array, no reset needed since occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/rv32_mmio_uart_tx.sv
// MMIO UART transmitter: decodes its 16-byte window, buffers written bytes in
// a FIFO and shifts them out 8N1 at a programmable baud divisor.
module rv32_mmio_uart_tx
  import rv32_mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic            clk,
  input  logic            resetn,
  input  memory_request_t request,
  output logic            request_done,
  output logic [31:0]     read_data,
  output logic            uart_tx,
  output logic            irq_tx_empty
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             hit;
  logic             wr_hit;
  logic             rd_hit;
  logic [1:0]       offset;
  logic             push_req;
  logic             overflow_event;
  logic [31:0]      read_data_d;
  logic [31:0]      read_data_q;
  logic [15:0]      divisor_q;
  logic             overflow_q;

  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_rdata;
  logic [CNT_W-1:0] fifo_count;

  uart_tx_state_t   state_q;
  logic [15:0]      baud_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             tx_q;
  logic             baud_done;
  logic             unused_req_bits;

  assign hit            = (request.op != MEM_NOP) && (request.addr[31:4] == BASE_ADDR[31:4]);
  assign wr_hit         = hit && (request.op == MEM_WRITE);
  assign rd_hit         = hit && (request.op == MEM_READ);
  assign offset         = request.addr[3:2];
  assign push_req       = wr_hit && (offset == UART_REG_TXDATA);
  assign overflow_event = push_req && fifo_full && !fifo_pop;
  assign request_done   = hit;
  assign read_data      = read_data_q;
  assign uart_tx        = tx_q;
  assign irq_tx_empty   = fifo_empty && (state_q == UART_IDLE);
  assign baud_done      = (baud_q == 16'd0);
  assign fifo_pop       = !fifo_empty &&
                          ((state_q == UART_IDLE) || ((state_q == UART_STOP) && baud_done));
  assign unused_req_bits = ^{request.data[31:16], request.addr[1:0]};

  rv32_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (push_req),
    .wdata_i (request.data[7:0]),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Register read mux; unmapped and write-only locations read as zero.
  always_comb begin
    read_data_d = 32'h0;
    case (offset)
      UART_REG_STATUS:  read_data_d = {16'h0, 8'(fifo_count), 4'h0,
                                       overflow_q, fifo_empty, fifo_full,
                                       (state_q != UART_IDLE)};
      UART_REG_DIVISOR: read_data_d = {16'h0, divisor_q};
      default:          read_data_d = 32'h0;
    endcase
  end

  // Read-data capture, divisor register and sticky overflow (a set beats a clearing read).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      read_data_q <= 32'h0;
      divisor_q   <= DEFAULT_DIV;
      overflow_q  <= 1'b0;
    end else begin
      if (rd_hit) read_data_q <= read_data_d;
      if (wr_hit && (offset == UART_REG_DIVISOR))
        divisor_q <= clamp_divisor(request.data[15:0]);
      if (overflow_event)
        overflow_q <= 1'b1;
      else if (rd_hit && (offset == UART_REG_STATUS))
        overflow_q <= 1'b0;
    end
  end

  // TX FSM: each state lasts divisor cycles; the divisor is sampled at every bit boundary.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= UART_IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'h0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        UART_IDLE: begin
          if (!fifo_empty) begin
            state_q <= UART_START;
            tx_q    <= 1'b0;
            baud_q  <= divisor_q - 16'd1;
            shift_q <= fifo_rdata;
          end
        end
        UART_START: begin
          if (baud_done) begin
            state_q <= UART_DATA;
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
            bit_q   <= 3'd0;
            baud_q  <= divisor_q - 16'd1;
          end else begin
            baud_q  <= baud_q - 16'd1;
          end
        end
        UART_DATA: begin
          if (baud_done) begin
            baud_q <= divisor_q - 16'd1;
            if (bit_q == 3'd7) begin
              state_q <= UART_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              tx_q    <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
            end
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        UART_STOP: begin
          if (baud_done) begin
            if (!fifo_empty) begin
              state_q <= UART_START;
              tx_q    <= 1'b0;
              baud_q  <= divisor_q - 16'd1;
              shift_q <= fifo_rdata;
            end else begin
              state_q <= UART_IDLE;
            end
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        default: begin
          state_q <= UART_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_mmio_uart_tx.sv
// Scoreboard bench for rv32_mmio_uart_tx: reads and transmitted bytes are
// queued as expectations and checked by independent monitor processes.
module tb_rv32_mmio_uart_tx;
  import rv32_mmio_uart_tx_pkg::*;

  localparam logic [31:0] A_TX  = 32'h8000_0000;
  localparam logic [31:0] A_ST  = 32'h8000_0004;
  localparam logic [31:0] A_DIV = 32'h8000_0008;
  localparam logic [31:0] A_RSV = 32'h8000_000C;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  memory_request_t req;
  logic            request_done;
  logic [31:0]     read_data;
  logic            uart_tx;
  logic            irq_tx_empty;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mon_div = 868;
  logic mon_en = 1'b1;
  logic [31:0] last_rd = 32'h0;
  logic [31:0] rd_q[$];
  logic [7:0]  tx_exp[$];
  int          start_times[$];

  rv32_mmio_uart_tx dut (
    .clk          (clk),
    .resetn       (resetn),
    .request      (req),
    .request_done (request_done),
    .read_data    (read_data),
    .uart_tx      (uart_tx),
    .irq_tx_empty (irq_tx_empty)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One bus transaction occupying exactly one clock cycle.
  task automatic bus_op(input mem_op_t op, input logic [31:0] addr, input logic [31:0] data,
                        input logic exp_done, input logic [31:0] exp_rd);
    req.op   = op;
    req.addr = addr;
    req.data = data;
    if (op == MEM_READ && exp_done) begin
      rd_q.push_back(exp_rd);
      last_rd = exp_rd;
    end
    @(negedge clk);
    chk("request_done", {31'h0, request_done}, {31'h0, exp_done});
    @(posedge clk);
    #1;
    req.op = MEM_NOP;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus_op(MEM_WRITE, addr, data, 1'b1, 32'h0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
    bus_op(MEM_READ, addr, 32'h0, 1'b1, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    while (!irq_tx_empty && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("tx_idle_within_budget", (n < budget) ? 32'd1 : 32'd0, 32'd1);
    repeat (4) @(negedge clk);
    chk("tx_queue_drained", tx_exp.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Read-data monitor: the cycle after a read hit, compare against the queue head.
  initial begin : rd_mon
    logic pend;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL read_unexpected actual=%h expected=none", read_data);
        end else begin
          chk("read_data", read_data, rd_q.pop_front());
        end
        pend = 1'b0;
      end
      if (resetn && request_done && req.op == MEM_READ) pend = 1'b1;
    end
  end

  // Serial monitor: decode each 8N1 frame mid-bit and compare with expected bytes.
  initial begin : tx_mon
    logic [7:0] b;
    logic       stop_bit;
    forever begin
      @(negedge clk);
      if (mon_en && resetn && uart_tx == 1'b0) begin
        start_times.push_back(cyc);
        repeat (mon_div / 2) @(negedge clk);
        chk("start_bit_mid", {31'h0, uart_tx}, 32'h0);
        for (int i = 0; i < 8; i++) begin
          repeat (mon_div) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (mon_div) @(negedge clk);
        stop_bit = uart_tx;
        chk("stop_bit", {31'h0, stop_bit}, 32'h1);
        if (tx_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_byte_unexpected actual=%h expected=none", b);
        end else begin
          chk("tx_byte", {24'h0, b}, {24'h0, tx_exp.pop_front()});
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    req = '0;
    req.op = MEM_NOP;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
    chk("rst_irq", {31'h0, irq_tx_empty}, 32'h1);
    chk("rst_done", {31'h0, request_done}, 32'h0);
    chk("rst_read_data", read_data, 32'h0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    idle(2);

    // Reset STATUS and default divisor
    rd(A_ST, 32'h0000_0004);
    rd(A_DIV, 32'h0000_0364);
    chk("idle_line", {31'h0, uart_tx}, 32'h1);

    // Divisor clamp, window decode, reserved offset
    wr(A_DIV, 32'h0000_0001);
    rd(A_DIV, 32'h0000_0002);
    wr(A_DIV, 32'h0000_0000);
    rd(A_DIV, 32'h0000_0002);
    bus_op(MEM_READ, 32'h8000_0010, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("miss_hi_keeps_data", read_data, last_rd);
    @(posedge clk); #1;
    bus_op(MEM_READ, 32'h7FFF_FFFC, 32'h0, 1'b0, 32'h0);
    bus_op(MEM_NOP, A_ST, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("nop_keeps_data", read_data, last_rd);
    @(posedge clk); #1;
    rd(A_RSV, 32'h0);
    wr(A_RSV, 32'hFFFF_FFFF);
    rd(A_DIV, 32'h0000_0002);
    rd(A_TX, 32'h0);

    // Single frame 0x55 at divisor 4
    wr(A_DIV, 32'd4);
    mon_div = 4;
    tx_exp.push_back(8'h55);
    wr(A_TX, 32'h55);
    wait_idle(200);
    rd(A_ST, 32'h0000_0004);

    // Push coinciding with the STOP->START pop; frames back-to-back
    start_times.delete();
    tx_exp.push_back(8'hA1);
    tx_exp.push_back(8'h3C);
    tx_exp.push_back(8'hF0);
    wr(A_TX, 32'hA1);
    wr(A_TX, 32'h3C);
    idle(38);
    rd(A_ST, 32'h0000_0101);
    wr(A_TX, 32'hF0);
    rd(A_ST, 32'h0000_0101);
    wait_idle(400);
    chk("frames_seen", start_times.size(), 32'd3);
    if (start_times.size() == 3) begin
      chk("gap_1", start_times[1] - start_times[0], 32'd40);
      chk("gap_2", start_times[2] - start_times[1], 32'd40);
    end

    // Overflow: one byte in flight, then 17 more into a 16-deep FIFO
    wr(A_DIV, 32'd100);
    mon_div = 100;
    tx_exp.push_back(8'h3C);
    wr(A_TX, 32'h3C);
    for (int i = 1; i <= 17; i++) begin
      if (i <= 16) tx_exp.push_back(8'(8'h80 + i));
      wr(A_TX, 32'(8'h80 + i));
    end
    rd(A_ST, 32'h0000_100B);
    rd(A_ST, 32'h0000_1003);
    wait_idle(20000);
    rd(A_ST, 32'h0000_0004);

    // Reset during DATA bit 3 of 0xA5
    wr(A_DIV, 32'd4);
    mon_div = 4;
    mon_en = 1'b0;
    wr(A_TX, 32'hA5);
    idle(18);
    resetn = 1'b0;
    @(negedge clk);
    chk("mid_frame_bit3", {31'h0, uart_tx}, 32'h0);
    @(negedge clk);
    chk("reset_uart_tx", {31'h0, uart_tx}, 32'h1);
    chk("reset_irq", {31'h0, irq_tx_empty}, 32'h1);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    rd(A_ST, 32'h0000_0004);
    rd(A_DIV, 32'h0000_0364);
    idle(10);
    @(negedge clk);
    chk("line_stays_idle", {31'h0, uart_tx}, 32'h1);
    repeat (2) @(negedge clk);
    chk("read_queue_drained", rd_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
